// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: two requester ports plus the shared data-memory bus.
interface dm_arbiter_if;
  logic        r0_req, r0_we, r0_gnt, r0_err, r0_rvalid;
  logic [2:0]  r0_size;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_gnt, r1_err, r1_rvalid;
  logic [2:0]  r1_size;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic        dm_we;
  logic [2:0]  dm_size;
  logic [31:0] dm_addr, dm_wd, dm_rd;
  modport master (
    output r0_req, r0_we, r0_size, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_size, r1_addr, r1_wdata, dm_rd,
    input  r0_gnt, r0_err, r0_rvalid, r0_rdata,
    input  r1_gnt, r1_err, r1_rvalid, r1_rdata,
    input  dm_we, dm_size, dm_addr, dm_wd
  );
  modport slave (
    input  r0_req, r0_we, r0_size, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_size, r1_addr, r1_wdata, dm_rd,
    output r0_gnt, r0_err, r0_rvalid, r0_rdata,
    output r1_gnt, r1_err, r1_rvalid, r1_rdata,
    output dm_we, dm_size, dm_addr, dm_wd
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbitration of two requesters onto one data memory port.
module dm_arbiter (
  input logic         clk,
  input logic         rst,
  dm_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t      state, state_n;
  logic        id, last, we_q, sel, any, ok_size, legal, issue, resp, busy;
  logic [2:0]  size_q;
  logic [31:0] addr_q, wd_q;
  assign any = bus.r0_req | bus.r1_req;
  // last holds the most recently granted requester; it resets to 1 so r0 wins first
  assign sel = (bus.r0_req & bus.r1_req) ? ~last : bus.r1_req;
  assign ok_size = we_q ? (size_q <= 3'd2) : (size_q <= 3'd2 || size_q == 3'd4 || size_q == 3'd5);
  assign legal = ok_size && !((size_q == 3'd1 || size_q == 3'd5) && addr_q[1:0] == 2'b11);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      id     <= 1'b0;
      last   <= 1'b1;
      we_q   <= 1'b0;
      size_q <= 3'd2;
      addr_q <= '0;
      wd_q   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any) begin
        id     <= sel;
        last   <= sel;
        we_q   <= sel ? bus.r1_we : bus.r0_we;
        size_q <= sel ? bus.r1_size : bus.r0_size;
        addr_q <= sel ? bus.r1_addr : bus.r0_addr;
        wd_q   <= sel ? bus.r1_wdata : bus.r0_wdata;
      end
    end
  end
  always_comb begin
    issue = state == ISSUE;
    resp = state == RESP;
    busy = issue | resp;
    state_n = state == IDLE ? (any ? ISSUE : IDLE) : (issue && legal && !we_q) ? RESP : IDLE;
    bus.dm_we = issue && we_q && legal;
    bus.dm_size = busy ? size_q : 3'd2;
    bus.dm_addr = busy ? addr_q : '0;
    bus.dm_wd = issue ? wd_q : '0;
    bus.r0_gnt = issue && !id;
    bus.r1_gnt = issue && id;
    bus.r0_err = issue && !id && !legal;
    bus.r1_err = issue && id && !legal;
    bus.r0_rvalid = resp && !id;
    bus.r1_rvalid = resp && id;
    bus.r0_rdata = (resp && !id) ? bus.dm_rd : '0;
    bus.r1_rdata = (resp && id) ? bus.dm_rd : '0;
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: randomized scoreboard bench with a byte-level memory and reference model.
module tb_dm_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  dm_arbiter_if bus();
  dm_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic rid; logic err; logic wr; logic [2:0] size; logic [31:0] addr; logic [31:0] wd; logic [31:0] data; } exp_t;
  exp_t q[$];
  exp_t me;
  int tests = 0, fails = 0;
  logic mon_en = 1'b1, mlast = 1'b1, pend = 1'b0, prid = 1'b0;
  logic [31:0] pdata = '0;
  logic [7:0] mem [64];
  logic [7:0] ref_mem [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext(input logic [2:0] s, input logic [31:0] r);
    return s == 3'd0 ? {{24{r[7]}}, r[7:0]} : s == 3'd4 ? {24'h0, r[7:0]} :
           s == 3'd1 ? {{16{r[15]}}, r[15:0]} : s == 3'd5 ? {16'h0, r[15:0]} : r;
  endfunction
  function automatic int nb(input logic [2:0] s);
    return s == 3'd0 ? 1 : s == 3'd1 ? 2 : 4;
  endfunction
  function automatic logic [31:0] dev_raw(input logic [31:0] a);
    return {mem[6'(a + 3)], mem[6'(a + 2)], mem[6'(a + 1)], mem[6'(a)]};
  endfunction
  function automatic logic [31:0] ref_raw(input logic [31:0] a);
    return {ref_mem[6'(a + 3)], ref_mem[6'(a + 2)], ref_mem[6'(a + 1)], ref_mem[6'(a)]};
  endfunction

  // Little-endian byte memory, 64 bytes wrapping, registered read with size extension
  always @(posedge clk) begin
    if (bus.dm_we)
      for (int i = 0; i < 4; i++)
        if (i < nb(bus.dm_size)) mem[6'(bus.dm_addr + i)] <= bus.dm_wd[8*i +: 8];
    bus.dm_rd <= ext(bus.dm_size, dev_raw(bus.dm_addr));
  end

  task automatic model_do(input logic rid, input logic w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic ok;
    ok = (w ? (s inside {3'd0, 3'd1, 3'd2}) : (s inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
         && !((s == 3'd1 || s == 3'd5) && a[1:0] == 2'b11);
    e.rid = rid; e.err = !ok; e.wr = w; e.size = s; e.addr = a; e.wd = d; e.data = '0;
    if (ok && w) for (int i = 0; i < nb(s); i++) ref_mem[6'(a + i)] = d[8*i +: 8];
    if (ok && !w) e.data = ext(s, ref_raw(a));
    q.push_back(e);
  endtask

  task automatic round(input logic u0, input logic u1,
                       input logic w0, input logic [2:0] s0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic w1, input logic [2:0] s1, input logic [31:0] a1, input logic [31:0] d1);
    logic f;
    int cnt;
    f = (u0 && u1) ? !mlast : u1;
    if (!f) begin
      model_do(1'b0, w0, s0, a0, d0);
      if (u1) model_do(1'b1, w1, s1, a1, d1);
    end else begin
      model_do(1'b1, w1, s1, a1, d1);
      if (u0) model_do(1'b0, w0, s0, a0, d0);
    end
    mlast = (u0 && u1) ? !f : f;
    @(negedge clk);
    bus.r0_we = w0; bus.r0_size = s0; bus.r0_addr = a0; bus.r0_wdata = d0; bus.r0_req = u0;
    bus.r1_we = w1; bus.r1_size = s1; bus.r1_addr = a1; bus.r1_wdata = d1; bus.r1_req = u1;
    cnt = 0;
    while ((bus.r0_req || bus.r1_req) && cnt < 20) begin
      @(negedge clk);
      if (bus.r0_gnt) begin
        bus.r0_req = 1'b0; bus.r0_addr = $urandom; bus.r0_size = 3'($urandom); bus.r0_wdata = $urandom; bus.r0_we = 1'($urandom);
      end
      if (bus.r1_gnt) begin
        bus.r1_req = 1'b0; bus.r1_addr = $urandom; bus.r1_size = 3'($urandom); bus.r1_wdata = $urandom; bus.r1_we = 1'($urandom);
      end
      cnt++;
    end
    if (cnt >= 20) begin
      chk("req_timeout", {30'h0, bus.r1_req, bus.r0_req}, 0);
      bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst) pend = 1'b0;
    else if (mon_en) begin
      if (pend) begin
        chk("rvalid", {30'h0, bus.r1_rvalid, bus.r0_rvalid}, prid ? 2 : 1);
        chk("rdata", prid ? bus.r1_rdata : bus.r0_rdata, pdata);
        chk("rdata_other", prid ? bus.r0_rdata : bus.r1_rdata, 0);
        pend = 1'b0;
      end else if (bus.r0_rvalid || bus.r1_rvalid)
        chk("spurious_rvalid", {30'h0, bus.r1_rvalid, bus.r0_rvalid}, 0);
      if (bus.r0_gnt || bus.r1_gnt) begin
        if (q.size() == 0) chk("unexpected_gnt", {30'h0, bus.r1_gnt, bus.r0_gnt}, 0);
        else begin
          me = q.pop_front();
          chk("gnt", {30'h0, bus.r1_gnt, bus.r0_gnt}, me.rid ? 2 : 1);
          chk("err", me.rid ? bus.r1_err : bus.r0_err, me.err);
          chk("err_other", me.rid ? bus.r0_err : bus.r1_err, 0);
          chk("dm_we", bus.dm_we, me.wr && !me.err);
          chk("dm_addr", bus.dm_addr, me.addr);
          chk("dm_size", bus.dm_size, me.size);
          if (me.wr && !me.err) chk("dm_wd", bus.dm_wd, me.wd);
          if (!me.wr && !me.err) begin
            pend = 1'b1; prid = me.rid; pdata = me.data;
          end
        end
      end else chk("dm_we_idle", bus.dm_we, 0);
    end
  end

  initial begin
    logic [1:0] u;
    for (int i = 0; i < 64; i++) begin mem[i] = 8'h0; ref_mem[i] = 8'h0; end
    bus.r0_req = 0; bus.r0_we = 0; bus.r0_size = 0; bus.r0_addr = 0; bus.r0_wdata = 0;
    bus.r1_req = 0; bus.r1_we = 0; bus.r1_size = 0; bus.r1_addr = 0; bus.r1_wdata = 0;
    #1;
    chk("rst_dm_size", bus.dm_size, 2);
    chk("rst_dm_we", bus.dm_we, 0);
    chk("rst_dm_addr", bus.dm_addr, 0);
    chk("rst_gnt", {30'h0, bus.r1_gnt, bus.r0_gnt}, 0);
    @(negedge clk); rst = 1'b0;
    // store then load back a word
    round(1, 0, 1, 2, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    round(1, 0, 0, 2, 32'h10, 0, 0, 0, 0, 0);
    // signed and unsigned byte loads of 0x80
    round(1, 0, 1, 0, 32'h13, 32'h80, 0, 0, 0, 0);
    round(0, 1, 0, 0, 0, 0, 0, 0, 32'h13, 0);
    round(0, 1, 0, 0, 0, 0, 0, 4, 32'h13, 0);
    // misaligned uhalf load and store with size 4 are errors
    round(1, 0, 0, 5, 32'h03, 0, 0, 0, 0, 0);
    round(1, 0, 1, 4, 32'h08, 32'h55, 0, 0, 0, 0);
    // contention alternates
    repeat (3) round(1, 1, 0, 2, 32'h10, 0, 0, 2, 32'h10, 0);
    // r1 request dropped before it is latched is ignored
    model_do(1'b0, 1'b1, 3'd2, 32'h30, 32'hA5A5_5A5A); mlast = 1'b0;
    @(negedge clk);
    bus.r0_we = 1; bus.r0_size = 2; bus.r0_addr = 32'h30; bus.r0_wdata = 32'hA5A5_5A5A; bus.r0_req = 1;
    @(negedge clk);
    bus.r0_req = 0; bus.r1_we = 0; bus.r1_size = 2; bus.r1_addr = 32'h30; bus.r1_req = 1;
    @(negedge clk); bus.r1_req = 0;
    repeat (3) @(negedge clk);
    // reset in the ISSUE cycle of a word store
    mon_en = 1'b0;
    @(negedge clk);
    bus.r0_we = 1; bus.r0_size = 2; bus.r0_addr = 32'h20; bus.r0_wdata = 32'h1234_5678; bus.r0_req = 1;
    @(negedge clk);
    chk("abort_gnt_seen", bus.r0_gnt, 1);
    rst = 1'b1; #1;
    chk("abort_dm_we", bus.dm_we, 0);
    chk("abort_gnt", {30'h0, bus.r1_gnt, bus.r0_gnt}, 0);
    chk("abort_dm_size", bus.dm_size, 2);
    bus.r0_req = 0;
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_quiet", {28'h0, bus.r1_gnt, bus.r0_gnt, bus.r1_rvalid, bus.r0_rvalid}, 0);
    end
    chk("abort_mem", dev_raw(32'h20), ref_raw(32'h20));
    mlast = 1'b1; mon_en = 1'b1;
    round(1, 1, 0, 2, 32'h20, 0, 0, 2, 32'h30, 0);
    for (int n = 0; n < 200; n++) begin
      u = 2'($urandom_range(1, 3));
      round(u[0], u[1], 1'($urandom), 3'($urandom), 32'($urandom_range(0, 63)), $urandom,
            1'($urandom), 3'($urandom), 32'($urandom_range(0, 63)), $urandom);
    end
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
